delay_ctrl_multi: RTL and testbench
===================================

Name: delay_ctrl_multi

Overview:
Parametrised successor to the single 4-bit blink-delay controller. Holds NCH independent saturating level registers (blink delay / sample-rate divisors) driven by one shared faster/slower button pair and a channel select. Adds configurable width, limits, step size, hold-to-auto-repeat, both-buttons preset, and status flags. Sits between the debounced button front end and the per-channel blinker/timer blocks.

Parameters:
WIDTH, 4, bits per channel level
NCH, 2, number of channels (>=1)
SEL_W, 1, select width; integrator sets to max(1, clog2(NCH))
MIN, 1, lower saturation limit
MAX, 15, upper saturation limit (MIN <= INIT <= MAX <= 2**WIDTH-1)
INIT, 8, reset and preset value
STEP, 1, increment/decrement per action (>=1)
REPEAT_DELAY, 8, cycles from first action to first auto-repeat; 0 disables auto-repeat
REPEAT_RATE, 4, cycles between subsequent auto-repeats (>=1)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
faster  in  1  decrement request, synchronous, already debounced
slower  in  1  increment request, synchronous, already debounced
sel  in  SEL_W  channel addressed by actions
delay  out  NCH*WIDTH  channel levels, channel k at bits [k*WIDTH +: WIDTH]
at_min  out  NCH  channel level == MIN
at_max  out  NCH  channel level == MAX
changed  out  1  one-cycle pulse, any level changed this cycle

Behaviour:
- Reset (reset_n low, async assert, sync release): all levels = INIT, changed = 0, hold FSM = IDLE, previous-command register = NONE. Mid-hold reset aborts the hold immediately.
- Command cmd = {faster, slower}: 10 = DEC, 01 = INC, 11 = PRESET, 00 = NONE.
- Action occurs when cmd differs from the previous cycle's cmd and is not NONE (new press or change, e.g. DEC -> PRESET), and on auto-repeat ticks.
- Latency: cmd sampled at edge N -> new level and changed = 1 visible after edge N; changed is registered alongside the level.
- DEC: level = max(level - STEP, MIN); INC: level = min(level + STEP, MAX). Compute in WIDTH+1 bits, no wrap-around.
- PRESET: level = INIT. Fires once per press and never auto-repeats.
- changed = 1 only if the target level actually differs. A saturated step or preset-at-INIT gives changed = 0.
- Only channel sel is affected. sel >= NCH: action ignored, FSM still runs.
- sel is sampled at each action. Changing sel during a hold redirects later repeats and does not restart the timer.
- Hold FSM, one down-counter of width clog2(max(REPEAT_DELAY, REPEAT_RATE)+1):
  - IDLE: on a new INC/DEC action, load REPEAT_DELAY and go to FIRST (stay in IDLE if REPEAT_DELAY = 0). PRESET stays in IDLE.
  - FIRST: count down while cmd is unchanged. At terminal count, act, load REPEAT_RATE and go to REPEAT.
  - REPEAT: at terminal count, act and reload REPEAT_RATE.
  - Any state: cmd = NONE -> IDLE. cmd changed to another INC/DEC -> act, reload REPEAT_DELAY, go to FIRST. cmd changed to PRESET -> act, go to IDLE.
- Resulting action timing for a hold starting at cycle 0: cycle 0, REPEAT_DELAY, REPEAT_DELAY + k*REPEAT_RATE.
- at_min/at_max are combinational compares of the registered levels. When MIN == MAX both flags are 1.

Decomposition:
- Package delay_ctrl_pkg:
  - cmd encoding constants (CMD_NONE/INC/DEC/PRESET)
  - hold FSM state typedef (IDLE, FIRST, REPEAT)
  - saturating add/sub function taking WIDTH, STEP, MIN and MAX
- Sub-module hold_repeat: cmd in -> one-cycle act strobe plus latched cmd out, parametrised by REPEAT_DELAY/REPEAT_RATE.
- Top level: channel array, decode, saturation, flags.

Test Plan:
- Reset: defaults, reset_n low -> delay = {8,8}, at_min = 00, at_max = 00, changed = 0. Assert reset_n mid-hold with ch0 = 12 -> ch0 = 8 asynchronously, FSM IDLE.
- Single press: faster high for 1 cycle, sel = 0 -> ch0 = 7 after that edge, ch1 = 8, changed high exactly 1 cycle.
- Auto-repeat: slower held 20 cycles, sel = 1 -> ch1 steps at cycles 0, 8, 12, 16; final ch1 = 12, 4 changed pulses; release -> no further steps.
- Saturation: faster held 100 cycles -> ch0 = 1, at_min[0] = 1, no changed pulses after reaching 1. Instance STEP = 3, 3 slower presses from 8 -> 11, 14, 15; at_max = 1.
- Preset: ch0 = 3, press faster then add slower (cmd 10 -> 11) -> ch0 = 3 - 1 = 2 then 8. Hold both 30 cycles -> single preset; preset at INIT -> changed = 0.
- Select: NCH = 3, SEL_W = 2, sel = 3 with slower pulses -> no level change, changed = 0. Switch sel 0 -> 1 during a hold -> later repeats land on ch1 with unchanged timing.

Source files
------------

// File: rtl/delay_ctrl_pkg.sv
// Shared command encoding, hold-FSM state type and saturating step helper
// for the multi-channel delay controller.
package delay_ctrl_pkg;

  localparam logic [1:0] CMD_NONE   = 2'b00;
  localparam logic [1:0] CMD_INC    = 2'b01;
  localparam logic [1:0] CMD_DEC    = 2'b10;
  localparam logic [1:0] CMD_PRESET = 2'b11;

  typedef enum logic [1:0] {
    HOLD_IDLE,
    HOLD_FIRST,
    HOLD_REPEAT
  } hold_state_e;

  // Arithmetic is done in 64 bits so neither direction can wrap; the upper
  // limit is additionally clamped to what a WIDTH-bit level can hold.
  function automatic int unsigned sat_step(
    input int unsigned level,
    input logic        inc,
    input int unsigned width,
    input int unsigned step,
    input int unsigned min_lvl,
    input int unsigned max_lvl
  );
    longint unsigned top;
    longint unsigned lvl;
    longint unsigned stp;
    longint unsigned lo;
    lvl = 64'(level);
    stp = 64'(step);
    lo  = 64'(min_lvl);
    top = (64'd1 << width) - 64'd1;
    if (64'(max_lvl) < top) top = 64'(max_lvl);
    if (inc) begin
      if (lvl + stp > top) return 32'(top);
      return 32'(lvl + stp);
    end
    if (lvl < lo + stp) return min_lvl;
    return 32'(lvl - stp);
  endfunction

endpackage

// File: rtl/delay_ctrl_multi_hold_repeat.sv
// Press/hold detector: one-cycle act strobe on every new command and on
// auto-repeat ticks while an INC/DEC command is held.
//
// state       | meaning
// HOLD_IDLE   | no repeating command (released, preset, or repeat disabled)
// HOLD_FIRST  | waiting out the initial repeat delay
// HOLD_REPEAT | repeating every REPEAT_RATE cycles
module hold_repeat
  import delay_ctrl_pkg::*;
#(
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] cmd,
  output logic       act,
  output logic [1:0] act_cmd
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  // Counter is loaded with N-1 so the terminal count (zero) lands exactly
  // N cycles after the action that loaded it.
  localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [CNT_W-1:0] RATE_LOAD  = CNT_W'(REPEAT_RATE - 1);

  hold_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= HOLD_IDLE;
      cnt_q   <= '0;
      prev_q  <= CMD_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= cmd;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    act     = 1'b0;
    if (cmd == CMD_NONE) begin
      state_d = HOLD_IDLE;
    end else if (cmd != prev_q) begin
      act   = 1'b1;
      cnt_d = DELAY_LOAD;
      if ((cmd == CMD_PRESET) || (REPEAT_DELAY == 0)) state_d = HOLD_IDLE;
      else                                            state_d = HOLD_FIRST;
    end else begin
      case (state_q)
        HOLD_FIRST, HOLD_REPEAT: begin
          if (cnt_q == '0) begin
            act     = 1'b1;
            cnt_d   = RATE_LOAD;
            state_d = HOLD_REPEAT;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign act_cmd = cmd;

endmodule

// File: rtl/delay_ctrl_multi.sv
// Multi-channel saturating level controller driven by a shared
// faster/slower button pair with hold-to-repeat and both-buttons preset.
module delay_ctrl_multi
  import delay_ctrl_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int NCH          = 2,
  parameter int SEL_W        = 1,
  parameter int MIN          = 1,
  parameter int MAX          = 15,
  parameter int INIT         = 8,
  parameter int STEP         = 1,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               faster,
  input  logic               slower,
  input  logic [SEL_W-1:0]   sel,
  output logic [NCH*WIDTH-1:0] delay,
  output logic [NCH-1:0]     at_min,
  output logic [NCH-1:0]     at_max,
  output logic               changed
);

  localparam logic [WIDTH-1:0] INIT_L = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] MIN_L  = WIDTH'(MIN);
  localparam logic [WIDTH-1:0] MAX_L  = WIDTH'(MAX);

  logic [1:0]       cmd;
  logic             act;
  logic [1:0]       act_cmd;
  logic [WIDTH-1:0] level_q [NCH];
  logic [WIDTH-1:0] level_d [NCH];
  logic             changed_d;

  assign cmd = {faster, slower};

  hold_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_hold (
    .clk     (clk),
    .reset_n (reset_n),
    .cmd     (cmd),
    .act     (act),
    .act_cmd (act_cmd)
  );

  // An out-of-range sel matches no channel, so the action is simply dropped.
  always_comb begin
    changed_d = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      level_d[k] = level_q[k];
      if (act && (int'(sel) == k)) begin
        case (act_cmd)
          CMD_INC: level_d[k] = WIDTH'(sat_step(32'(level_q[k]), 1'b1, WIDTH, STEP, MIN, MAX));
          CMD_DEC: level_d[k] = WIDTH'(sat_step(32'(level_q[k]), 1'b0, WIDTH, STEP, MIN, MAX));
          default: level_d[k] = INIT_L;
        endcase
        changed_d = changed_d | (level_d[k] != level_q[k]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NCH; k++) level_q[k] <= INIT_L;
      changed <= 1'b0;
    end else begin
      for (int k = 0; k < NCH; k++) level_q[k] <= level_d[k];
      changed <= changed_d;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    assign delay[k*WIDTH +: WIDTH] = level_q[k];
    assign at_min[k] = (level_q[k] == MIN_L);
    assign at_max[k] = (level_q[k] == MAX_L);
  end

endmodule

// File: tb/tb_delay_ctrl_multi.sv
// Directed and random checks of three delay_ctrl_multi instances against a
// cycle-level reference model of the press/hold/saturate rules.
module tb_delay_ctrl_multi;

  localparam int MINV  = 1;
  localparam int MAXV  = 15;
  localparam int INITV = 8;
  localparam int RD    = 8;
  localparam int RR    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n = 1'b1;
  logic       fa [3];
  logic       sl [3];
  logic [1:0] se [3];
  logic       chg [3];

  logic [7:0]  dly_a, dly_b;
  logic [11:0] dly_c;
  logic [1:0]  amin_a, amax_a, amin_b, amax_b;
  logic [2:0]  amin_c, amax_c;

  delay_ctrl_multi u_a (
    .clk(clk), .reset_n(reset_n), .faster(fa[0]), .slower(sl[0]), .sel(se[0][0:0]),
    .delay(dly_a), .at_min(amin_a), .at_max(amax_a), .changed(chg[0])
  );

  delay_ctrl_multi #(.STEP(3)) u_b (
    .clk(clk), .reset_n(reset_n), .faster(fa[1]), .slower(sl[1]), .sel(se[1][0:0]),
    .delay(dly_b), .at_min(amin_b), .at_max(amax_b), .changed(chg[1])
  );

  delay_ctrl_multi #(.NCH(3), .SEL_W(2)) u_c (
    .clk(clk), .reset_n(reset_n), .faster(fa[2]), .slower(sl[2]), .sel(se[2]),
    .delay(dly_c), .at_min(amin_c), .at_max(amax_c), .changed(chg[2])
  );

  int total = 0;
  int bad   = 0;
  int pulses [3];

  // reference model state
  int lvl [3][3];
  int prv [3];
  int age [3];
  bit rep_on [3];
  bit e_chg [3];
  int nch_of [3]  = '{2, 2, 3};
  int step_of [3] = '{1, 3, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] act_dly(input int m);
    case (m)
      0:       return {4'b0, dly_a};
      1:       return {4'b0, dly_b};
      default: return dly_c;
    endcase
  endfunction

  function automatic logic [2:0] act_min(input int m);
    case (m)
      0:       return {1'b0, amin_a};
      1:       return {1'b0, amin_b};
      default: return amin_c;
    endcase
  endfunction

  function automatic logic [2:0] act_max(input int m);
    case (m)
      0:       return {1'b0, amax_a};
      1:       return {1'b0, amax_b};
      default: return amax_c;
    endcase
  endfunction

  function automatic logic [11:0] exp_dly(input int m);
    logic [11:0] v;
    v = '0;
    for (int c = 0; c < nch_of[m]; c++) v[c*4 +: 4] = 4'(lvl[m][c]);
    return v;
  endfunction

  function automatic logic [2:0] exp_flag(input int m, input int lim);
    logic [2:0] v;
    v = '0;
    for (int c = 0; c < nch_of[m]; c++) v[c] = (lvl[m][c] == lim);
    return v;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 3; m++) begin
      for (int c = 0; c < 3; c++) lvl[m][c] = INITV;
      prv[m] = 0;
      age[m] = 0;
      rep_on[m] = 1'b0;
      e_chg[m] = 1'b0;
    end
  endtask

  // Actions: every new non-NONE command; while INC/DEC is held, at hold ages
  // RD, RD+RR, RD+2*RR, ...
  task automatic model_step(input int m);
    int cmd, s, t;
    bit a;
    cmd = 2 * int'(fa[m]) + int'(sl[m]);
    s   = (m < 2) ? int'(se[m][0]) : int'(se[m]);
    a   = 1'b0;
    if (cmd == 0) begin
      rep_on[m] = 1'b0;
    end else if (cmd != prv[m]) begin
      a = 1'b1;
      age[m] = 0;
      rep_on[m] = (cmd != 3) && (RD != 0);
    end else if (rep_on[m]) begin
      age[m]++;
      if (age[m] >= RD && ((age[m] - RD) % RR) == 0) a = 1'b1;
    end
    prv[m] = cmd;
    e_chg[m] = 1'b0;
    if (a && s < nch_of[m]) begin
      case (cmd)
        1:       t = (lvl[m][s] + step_of[m] > MAXV) ? MAXV : lvl[m][s] + step_of[m];
        2:       t = (lvl[m][s] - step_of[m] < MINV) ? MINV : lvl[m][s] - step_of[m];
        default: t = INITV;
      endcase
      e_chg[m] = (t != lvl[m][s]);
      lvl[m][s] = t;
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("delay%0d", m), 32'(act_dly(m)), 32'(exp_dly(m)));
      chk($sformatf("changed%0d", m), 32'(chg[m]), 32'(e_chg[m]));
      chk($sformatf("at_min%0d", m), 32'(act_min(m)), 32'(exp_flag(m, MINV)));
      chk($sformatf("at_max%0d", m), 32'(act_max(m)), 32'(exp_flag(m, MAXV)));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int m = 0; m < 3; m++) model_step(m);
    #1;
    check_all();
    for (int m = 0; m < 3; m++) pulses[m] += int'(chg[m]);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive(input int m, input bit f, input bit s, input int sel);
    fa[m] = f;
    sl[m] = s;
    se[m] = 2'(sel);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    for (int m = 0; m < 3; m++) begin
      drive(m, 1'b0, 1'b0, 0);
      pulses[m] = 0;
    end
    model_reset();
    #2;
    apply_reset();
    chk("rst_delay", 32'(dly_a), 32'h88);
    chk("rst_at_min", 32'(amin_a), 0);
    chk("rst_at_max", 32'(amax_a), 0);
    chk("rst_changed", 32'(chg[0]), 0);

    // single press
    drive(0, 1'b1, 1'b0, 0);
    tick();
    chk("single_ch0", 32'(dly_a[3:0]), 7);
    chk("single_ch1", 32'(dly_a[7:4]), 8);
    chk("single_pulse", 32'(chg[0]), 1);
    drive(0, 1'b0, 1'b0, 0);
    tick();
    chk("single_pulse_end", 32'(chg[0]), 0);

    // auto-repeat on ch1: actions at 0, 8, 12, 16
    pulses[0] = 0;
    drive(0, 1'b0, 1'b1, 1);
    ticks(20);
    chk("repeat_ch1", 32'(dly_a[7:4]), 12);
    chk("repeat_pulses", 32'(pulses[0]), 4);
    drive(0, 1'b0, 1'b0, 1);
    ticks(10);
    chk("repeat_release", 32'(pulses[0]), 4);

    // saturation at MIN
    pulses[0] = 0;
    drive(0, 1'b1, 1'b0, 0);
    ticks(100);
    chk("sat_min_ch0", 32'(dly_a[3:0]), 1);
    chk("sat_min_flag", 32'(amin_a[0]), 1);
    chk("sat_min_pulses", 32'(pulses[0]), 6);
    drive(0, 1'b0, 1'b0, 0);
    tick();

    // STEP=3 saturation at MAX
    for (int i = 0; i < 3; i++) begin
      drive(1, 1'b0, 1'b1, 0);
      tick();
      chk($sformatf("step3_press%0d", i), 32'(dly_b[3:0]), (i == 0) ? 11 : (i == 1) ? 14 : 15);
      drive(1, 1'b0, 1'b0, 0);
      tick();
    end
    chk("step3_at_max", 32'(amax_b[0]), 1);

    // preset: 1 -> 3, then DEC -> PRESET
    for (int i = 0; i < 2; i++) begin
      drive(0, 1'b0, 1'b1, 0);
      tick();
      drive(0, 1'b0, 1'b0, 0);
      tick();
    end
    chk("preset_setup", 32'(dly_a[3:0]), 3);
    drive(0, 1'b1, 1'b0, 0);
    tick();
    chk("preset_dec", 32'(dly_a[3:0]), 2);
    drive(0, 1'b1, 1'b1, 0);
    tick();
    chk("preset_init", 32'(dly_a[3:0]), 8);
    drive(0, 1'b0, 1'b0, 0);
    tick();
    drive(0, 1'b1, 1'b0, 0);
    tick();
    drive(0, 1'b0, 1'b0, 0);
    tick();
    pulses[0] = 0;
    drive(0, 1'b1, 1'b1, 0);
    ticks(30);
    chk("preset_hold_pulses", 32'(pulses[0]), 1);
    chk("preset_hold_ch0", 32'(dly_a[3:0]), 8);
    drive(0, 1'b0, 1'b0, 0);
    tick();
    drive(0, 1'b1, 1'b1, 0);
    tick();
    chk("preset_at_init", 32'(chg[0]), 0);
    drive(0, 1'b0, 1'b0, 0);
    tick();

    // out-of-range select on the 3-channel instance
    pulses[2] = 0;
    for (int i = 0; i < 3; i++) begin
      drive(2, 1'b0, 1'b1, 3);
      tick();
      drive(2, 1'b0, 1'b0, 3);
      tick();
    end
    chk("sel_oob_delay", 32'(dly_c), 32'h888);
    chk("sel_oob_pulses", 32'(pulses[2]), 0);

    // redirect a hold from ch0 to ch1 mid-delay
    drive(2, 1'b0, 1'b1, 0);
    ticks(5);
    drive(2, 1'b0, 1'b1, 1);
    ticks(9);
    chk("sel_switch_ch0", 32'(dly_c[3:0]), 9);
    chk("sel_switch_ch1", 32'(dly_c[7:4]), 10);
    drive(2, 1'b0, 1'b0, 1);
    tick();

    // reset during a hold
    drive(0, 1'b0, 1'b1, 0);
    ticks(17);
    chk("midhold_ch0", 32'(dly_a[3:0]), 12);
    apply_reset();
    chk("midhold_reset", 32'(dly_a), 32'h88);
    tick();
    chk("post_reset_press", 32'(dly_a[3:0]), 9);
    ticks(10);
    drive(0, 1'b0, 1'b0, 0);
    tick();

    // random phase
    for (int i = 0; i < 400; i++) begin
      for (int m = 0; m < 3; m++) begin
        if ($urandom_range(0, 7) == 0) begin
          fa[m] = 1'($urandom_range(0, 1));
          sl[m] = 1'($urandom_range(0, 1));
        end
        if ($urandom_range(0, 15) == 0)
          se[m] = (m < 2) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
